// File: rtl/team_06_input_emulator.sv
// Drives quadrature encoder phases and button press/release pulses from a one-deep command handshake.
// All outputs are registered; a zero-count or invalid command stays idle and flags done one cycle later.
module team_06_input_emulator #(
  parameter int DWELL = 8,
  parameter int HOLD  = 6000,
  parameter int GAP   = 6000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_count,
  output logic [1:0] vol,
  output logic [3:0] pbs,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, STEP, PRESS, RELEASE} state_t;

  localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);
  localparam logic [15:0] HOLD_M1  = 16'(HOLD - 1);
  localparam logic [15:0] GAP_M1   = 16'(GAP - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  rem, rem_nxt;
  logic        acw, acw_nxt;
  logic [1:0]  btn, btn_nxt;
  logic        zpend, zpend_nxt;
  logic [1:0]  vol_nxt;
  logic [3:0]  pbs_nxt;
  logic        done_nxt;
  logic [2:0]  op_m2;

  assign op_m2 = cmd_op - 3'd2;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      acw   <= 1'b0;
      btn   <= '0;
      zpend <= 1'b0;
      vol   <= 2'b00;
      pbs   <= 4'b0000;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rem   <= rem_nxt;
      acw   <= acw_nxt;
      btn   <= btn_nxt;
      zpend <= zpend_nxt;
      vol   <= vol_nxt;
      pbs   <= pbs_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rem_nxt   = rem;
    acw_nxt   = acw;
    btn_nxt   = btn;
    zpend_nxt = 1'b0;
    vol_nxt   = vol;
    pbs_nxt   = pbs;
    done_nxt  = zpend;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_count == 4'd0 || cmd_op > 3'd5) begin
            zpend_nxt = 1'b1;
          end else if (cmd_op < 3'd2) begin
            state_nxt = STEP;
            acw_nxt   = cmd_op[0];
            rem_nxt   = cmd_count;
            cnt_nxt   = '0;
          end else begin
            // Entering with an expired gap makes the first press land on the next edge.
            state_nxt = RELEASE;
            btn_nxt   = op_m2[1:0];
            rem_nxt   = cmd_count;
            cnt_nxt   = '0;
          end
        end
      end
      STEP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 16'd1;
        end else if (rem != '0) begin
          // Gray step: CW 00->01->11->10, ACW the reverse.
          vol_nxt = acw ? {~vol[0], vol[1]} : {vol[0], ~vol[1]};
          rem_nxt = rem - 4'd1;
          cnt_nxt = DWELL_M1;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      RELEASE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 16'd1;
        end else if (rem != '0) begin
          pbs_nxt   = 4'b0001 << btn;
          rem_nxt   = rem - 4'd1;
          cnt_nxt   = HOLD_M1;
          state_nxt = PRESS;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      PRESS: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 16'd1;
        end else begin
          pbs_nxt   = 4'b0000;
          cnt_nxt   = GAP_M1;
          state_nxt = RELEASE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
  end

endmodule

// File: tb/tb_team_06_input_emulator.sv
// Randomized command stream; expected output change events are queued by a timing model and popped by a monitor.
module tb_team_06_input_emulator;
  localparam int DWELL = 8;
  localparam int HOLD  = 4;
  localparam int GAP   = 3;
  localparam int PER   = HOLD + GAP;

  logic       clk = 1'b0;
  logic       nrst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_count;
  logic [1:0] vol;
  logic [3:0] pbs;
  logic       done;

  team_06_input_emulator #(.DWELL(DWELL), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .vol(vol), .pbs(pbs), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int val; int at;} ev_t;  // kind: 0 done, 1 vol, 2 pbs
  ev_t exp_q[$];

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int mpos = 0;
  int seen_net = 0;
  bit in_rst = 1'b1;
  logic [1:0] seq [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input int kind, input int val, input int at);
    ev_t e;
    e.kind = kind; e.val = val; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event kind=%0d actual val=%0d at=%0d required none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.val == val && e.at == cyc) passes++;
      else $display("FAIL event actual kind=%0d val=%0d at=%0d required kind=%0d val=%0d at=%0d",
                    kind, val, cyc, e.kind, e.val, e.at);
    end
  endtask

  function automatic int pos_of(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    logic [1:0] pv;
    logic [3:0] pp;
    int d;
    pv = 2'b00; pp = 4'b0000;
    forever begin
      @(posedge clk);
      #2;
      if (in_rst) begin
        pv = vol; pp = pbs;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
          checks++;
          $display("FAIL missed_event actual none required kind=%0d val=%0d at=%0d",
                   exp_q[0].kind, exp_q[0].val, exp_q[0].at);
          void'(exp_q.pop_front());
        end
        if (done === 1'b1) observe(0, 1);
        if (vol !== pv) begin
          observe(1, int'(vol));
          d = (pos_of(vol) - pos_of(pv) + 4) % 4;
          if (d == 1) seen_net++;
          else if (d == 3) seen_net--;
        end
        if (pbs !== pp) observe(2, int'(pbs));
        pv = vol; pp = pbs;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Issues one command, records the model's expected events, optionally wiggles cmd_valid while busy.
  task automatic issue(input logic [2:0] op, input logic [3:0] n, input bit noise, output int k, output int endc);
    bit ok;
    int b;
    wait_ready(ok);
    k = 0; endc = 0;
    if (!ok) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_count = n;
    @(posedge clk);
    #1;
    k = cyc;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_count = 4'($urandom);
    if (n == 0 || op > 5) begin
      endc = k + 1;
      push(0, 1, endc);
    end else if (op < 2) begin
      for (int i = 1; i <= int'(n); i++) begin
        mpos = (op == 0) ? (mpos + 1) % 4 : (mpos + 3) % 4;
        push(1, int'(seq[mpos]), k + 1 + (i - 1) * DWELL);
      end
      endc = k + 1 + int'(n) * DWELL;
      push(0, 1, endc);
    end else begin
      b = 1 << (int'(op) - 2);
      for (int i = 1; i <= int'(n); i++) begin
        push(2, b, k + 1 + (i - 1) * PER);
        push(2, 0, k + 1 + (i - 1) * PER + HOLD);
      end
      endc = k + 1 + int'(n) * PER;
      push(0, 1, endc);
    end
    if (noise && endc > k + 1) begin
      forever begin
        @(negedge clk);
        if (cyc >= endc) begin
          cmd_valid = 1'b0;
          break;
        end
        cmd_valid = 1'($urandom);
        cmd_op    = 3'($urandom);
        cmd_count = 4'($urandom);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k, e, net0;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    nrst = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd0; cmd_count = 4'd5;

    // Reset held for two edges with a command presented.
    @(negedge clk); @(negedge clk);
    chk("rst_vol", int'(vol), 0);
    chk("rst_pbs", int'(pbs), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    cmd_valid = 1'b0; nrst = 1'b1;
    @(negedge clk);
    chk("rst_no_accept", int'(cmd_ready), 1);
    chk("rst_vol_hold", int'(vol), 0);
    in_rst = 1'b0;

    // Directed cases from the plan.
    issue(3'd0, 4'd4, 1'b0, k, e);
    drain();
    issue(3'd1, 4'd3, 1'b0, k, e);
    issue(3'd0, 4'd1, 1'b0, k, e);
    drain();
    net0 = seen_net;
    issue(3'd0, 4'd5, 1'b0, k, e);
    issue(3'd1, 4'd2, 1'b0, k, e);
    drain();
    chk("loopback_volume", seen_net - net0, 3);
    issue(3'd3, 4'd2, 1'b1, k, e);
    drain();
    issue(3'd2, 4'd0, 1'b0, k, e);
    issue(3'd7, 4'd9, 1'b0, k, e);
    drain();

    // Reset in the middle of a quadrature-step command, right after its second transition.
    issue(3'd0, 4'd4, 1'b0, k, e);
    while (cyc < k + 1 + DWELL) @(negedge clk);
    in_rst = 1'b1;
    exp_q.delete();
    mpos = 0;
    nrst = 1'b0;
    @(negedge clk);
    chk("midrst_vol", int'(vol), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_done", int'(done), 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("midrst_done_after", int'(done), 0);
    in_rst = 1'b0;
    issue(3'd0, 4'd1, 1'b0, k, e);
    drain();

    // Randomized commands.
    for (int i = 0; i < 30; i++) begin
      issue(3'($urandom), 4'($urandom), 1'($urandom), k, e);
    end
    drain();
    chk("final_ready", int'(cmd_ready), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
